// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port screen RAM arbiter: video fetch with absolute priority, CPU access FSM
//
// Purpose:
//   Shares one single-port synchronous RAM (1-cycle read latency) between the
//   video fetcher and a CPU port. A video fetch is issued whenever the video
//   address moves (or after reset); the CPU gets the RAM only in cycles with
//   no video fetch due. CPU accesses take IDLE -> ISSUED -> ACK, three cycles
//   minimum. Screen bytes at or beyond SCREEN_BYTES read as 0xFF and are not
//   written.
//
// Ports:
//   clk_pix       pixel clock, all state updates on its rising edge
//   reset         asynchronous active-high reset
//   vram_address  video fetch address
//   vram_data     video read data (RAM data in the cycle after a fetch, hold register otherwise)
//   cpu_req       CPU request, held high until cpu_ack
//   cpu_we        CPU write enable (1 = write), sampled with cpu_req
//   cpu_addr      CPU screen offset
//   cpu_wdata     CPU write data
//   cpu_rdata     registered CPU read data, valid while cpu_ack=1
//   cpu_ack       one-cycle completion pulse
//   mem_addr      RAM address (holds its previous value when the RAM is idle)
//   mem_we        RAM write enable
//   mem_wdata     RAM write data
//   mem_rdata     RAM read data, one cycle after the address

module vram_arbiter #(
  parameter int SCREEN_BYTES = 6912
) (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic [12:0] vram_address,
  output logic [7:0]  vram_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  // One bit wider than the address so a full 8 KiB screen still compares correctly.
  localparam logic [13:0] LIMIT = 14'(SCREEN_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUED = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Video side
  logic [12:0] r_va_q;          // last fetched video address
  logic        r_force_fetch;   // fetch even if the address did not move (after reset)
  logic [7:0]  r_vhold;         // video data shown between fetches
  logic        r_vid_oor;       // last video fetch was beyond the screen

  // Which consumer owns mem_rdata in the current cycle
  logic        r_issue_act;     // the RAM was issued an access last cycle
  logic        r_issue_vid;     // ...and that access was a video fetch

  // CPU side
  logic        r_cpu_we_q;
  logic        r_cpu_oor;
  logic [7:0]  r_cpu_rdata;

  // RAM port hold registers
  logic [12:0] r_mem_addr_q;
  logic [7:0]  r_mem_wdata_q;

  logic        w_video_due;
  logic        w_cpu_issue;
  logic        w_cpu_in_range;
  logic        w_vid_in_range;
  logic        w_cpu_mem_we;
  logic        w_snoop;
  logic        w_vid_data_phase;
  logic        w_cpu_capture;
  logic [7:0]  w_vid_rdata;

  assign w_vid_in_range   = ({1'b0, vram_address} < LIMIT);
  assign w_cpu_in_range   = ({1'b0, cpu_addr} < LIMIT);
  assign w_video_due      = r_force_fetch || (vram_address != r_va_q);

  // The CPU may only start from IDLE, and only when video does not want the RAM.
  assign w_cpu_issue      = (r_state == S_IDLE) && cpu_req && !w_video_due;
  assign w_cpu_mem_we     = cpu_we && w_cpu_in_range;

  // A CPU write to the byte video is currently showing must be reflected
  // without another fetch; no fetch is due in a CPU issue cycle, so r_va_q
  // equals the displayed address.
  assign w_snoop          = w_cpu_issue && w_cpu_mem_we && (cpu_addr == r_va_q);

  assign w_vid_data_phase = r_issue_act && r_issue_vid;
  assign w_vid_rdata      = r_vid_oor ? 8'hFF : mem_rdata;

  // Read capture only takes RAM data that belongs to the CPU's own issue.
  assign w_cpu_capture    = (r_state == S_ISSUED) && r_issue_act && !r_issue_vid && !r_cpu_we_q;

  assign vram_data = w_vid_data_phase ? w_vid_rdata : r_vhold;
  assign cpu_rdata = r_cpu_rdata;

  // RAM port mux: video first, then a CPU issue, otherwise hold the last
  // address/data with the write strobe low. Reset forces the port to zero
  // immediately rather than waiting for the held registers.
  always_comb begin
    mem_addr  = r_mem_addr_q;
    mem_we    = 1'b0;
    mem_wdata = r_mem_wdata_q;
    if (reset) begin
      mem_addr  = 13'd0;
      mem_wdata = 8'd0;
    end else if (w_video_due) begin
      mem_addr  = vram_address;
    end else if (w_cpu_issue) begin
      mem_addr  = cpu_addr;
      mem_we    = w_cpu_mem_we;
      mem_wdata = cpu_wdata;
    end
  end

  // CPU FSM: state register
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // CPU FSM: next state and ack
  always_comb begin
    w_state_next = r_state;
    cpu_ack      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cpu_issue) begin
          w_state_next = S_ISSUED;
        end
      end
      S_ISSUED: begin
        w_state_next = S_ACK;
      end
      S_ACK: begin
        cpu_ack      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      r_va_q        <= 13'd0;
      r_force_fetch <= 1'b1;
      r_vhold       <= 8'd0;
      r_vid_oor     <= 1'b0;
      r_issue_act   <= 1'b0;
      r_issue_vid   <= 1'b0;
      r_cpu_we_q    <= 1'b0;
      r_cpu_oor     <= 1'b0;
      r_cpu_rdata   <= 8'd0;
      r_mem_addr_q  <= 13'd0;
      r_mem_wdata_q <= 8'd0;
    end else begin
      r_mem_addr_q  <= mem_addr;
      r_mem_wdata_q <= mem_wdata;

      r_issue_act   <= w_video_due || w_cpu_issue;
      r_issue_vid   <= w_video_due;

      if (w_video_due) begin
        r_va_q        <= vram_address;
        r_force_fetch <= 1'b0;
        r_vid_oor     <= !w_vid_in_range;
      end

      // The snoop wins over a fetch landing in the same cycle: the fetch
      // returned the byte as it was before this write.
      if (w_snoop) begin
        r_vhold <= cpu_wdata;
      end else if (w_vid_data_phase) begin
        r_vhold <= w_vid_rdata;
      end

      if (w_cpu_issue) begin
        r_cpu_we_q <= cpu_we;
        r_cpu_oor  <= !w_cpu_in_range;
      end

      if (w_cpu_capture) begin
        r_cpu_rdata <= r_cpu_oor ? 8'hFF : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter

module tb_vram_arbiter;

  localparam int SB = 6912;

  logic        clk_pix = 1'b0;
  logic        reset;
  logic [12:0] vram_address;
  logic [7:0]  vram_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk_pix = ~clk_pix;

  vram_arbiter #(.SCREEN_BYTES(SB)) dut (
    .clk_pix      (clk_pix),
    .reset        (reset),
    .vram_address (vram_address),
    .vram_data    (vram_data),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Single-port synchronous RAM, read-before-write, with a bench preload port.
  logic [7:0]  ram [0:8191];
  logic        pl_we;
  logic [12:0] pl_addr;
  logic [7:0]  pl_data;

  always @(posedge clk_pix) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Directed vectors: one row per clock cycle.
  typedef struct {
    logic [12:0] va;
    logic        req;
    logic        we;
    logic [12:0] ca;
    logic [7:0]  wd;
    logic [12:0] e_ma;
    logic        e_we;
    logic [7:0]  e_vd;
    logic        e_ack;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t vec[$];

  task automatic row(input logic [12:0] va, input logic req, input logic we,
                     input logic [12:0] ca, input logic [7:0] wd,
                     input logic [12:0] e_ma, input logic e_we, input logic [7:0] e_vd,
                     input logic e_ack, input logic [7:0] e_rd);
    vec_t v;
    v.va = va; v.req = req; v.we = we; v.ca = ca; v.wd = wd;
    v.e_ma = e_ma; v.e_we = e_we; v.e_vd = e_vd; v.e_ack = e_ack; v.e_rd = e_rd;
    vec.push_back(v);
  endtask

  // Reference model: expected screen contents plus the address video shows.
  logic [7:0]  shadow [0:8191];
  logic [12:0] m_va;
  logic        m_force;
  logic        m_valid;
  int          m_phase;      // 0 waiting, 1 issued, 2 acknowledging
  logic        m_we_q;
  logic [7:0]  m_pend;
  logic [7:0]  m_rdata;
  logic [12:0] m_last_addr;
  logic        prev_ack;

  function automatic logic [7:0] view(input logic [12:0] a);
    if (int'(a) >= SB) return 8'hFF;
    return shadow[a];
  endfunction

  function automatic logic [12:0] pick_addr(input logic [12:0] cur);
    case ($urandom_range(5, 0))
      0: return cur;
      1: return 13'h1AFF;
      2: return 13'h1B00 + 13'($urandom_range(3, 0));
      3: return 13'h1800 + 13'($urandom_range(3, 0));
      4: return 13'($urandom_range(31, 0));
      default: return 13'($urandom);
    endcase
  endfunction

  task automatic new_op();
    cpu_we    = 1'($urandom_range(1, 0));
    cpu_addr  = pick_addr(vram_address);
    cpu_wdata = 8'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic        vid_due;
    logic        cpu_issue;
    logic        e_we;
    logic [12:0] e_addr;
    logic [7:0]  e_vd;
    logic        e_ack;
    logic [12:0] a;
    logic [7:0]  d;

    reset = 1'b1;
    vram_address = 13'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'd0; cpu_wdata = 8'd0;
    pl_we = 1'b0; pl_addr = 13'd0; pl_data = 8'd0;

    // Preload RAM while the DUT is held in reset.
    for (int i = 0; i < 8192; i++) begin
      @(negedge clk_pix);
      a = 13'(i);
      d = a[7:0] ^ 8'h3C;
      if (a == 13'h0123) d = 8'h5A;
      if (a == 13'h0040) d = 8'h77;
      pl_we = 1'b1; pl_addr = a; pl_data = d;
    end
    @(negedge clk_pix);
    pl_we = 1'b0;

    // Reset state, with inputs that would otherwise drive the RAM port.
    vram_address = 13'h0777; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0055; cpu_wdata = 8'hEE;
    #1;
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_vram_data", 32'(vram_data), 32'h0);

    //  va       req we ca       wd      e_ma     we vd     ack rd
    row(13'h0000, 0, 0, 13'h0000, 8'h00, 13'h0000, 0, 8'h00, 0, 8'h00); // forced fetch after reset
    row(13'h0123, 0, 0, 13'h0000, 8'h00, 13'h0123, 0, 8'h3C, 0, 8'h00); // fetch latency
    row(13'h0123, 0, 0, 13'h0000, 8'h00, 13'h0123, 0, 8'h5A, 0, 8'h00);
    row(13'h0123, 0, 0, 13'h0000, 8'h00, 13'h0123, 0, 8'h5A, 0, 8'h00);
    row(13'h0005, 1, 0, 13'h0040, 8'h00, 13'h0005, 0, 8'h5A, 0, 8'h00); // contention: video first
    row(13'h0005, 1, 0, 13'h0040, 8'h00, 13'h0040, 0, 8'h39, 0, 8'h00);
    row(13'h0005, 1, 0, 13'h0040, 8'h00, 13'h0040, 0, 8'h39, 0, 8'h00);
    row(13'h0005, 1, 0, 13'h0040, 8'h00, 13'h0040, 0, 8'h39, 1, 8'h77);
    row(13'h0005, 0, 0, 13'h0000, 8'h00, 13'h0040, 0, 8'h39, 0, 8'h77);
    row(13'h1800, 0, 0, 13'h0000, 8'h00, 13'h1800, 0, 8'h39, 0, 8'h77); // snoop
    row(13'h1800, 1, 1, 13'h1800, 8'h47, 13'h1800, 1, 8'h3C, 0, 8'h77);
    row(13'h1800, 1, 1, 13'h1800, 8'h47, 13'h1800, 0, 8'h47, 0, 8'h77);
    row(13'h1800, 1, 1, 13'h1800, 8'h47, 13'h1800, 0, 8'h47, 1, 8'h77);
    row(13'h1800, 0, 0, 13'h0000, 8'h00, 13'h1800, 0, 8'h47, 0, 8'h77);
    row(13'h1800, 1, 1, 13'h1B00, 8'h99, 13'h1B00, 0, 8'h47, 0, 8'h77); // out-of-range write
    row(13'h1800, 1, 1, 13'h1B00, 8'h99, 13'h1B00, 0, 8'h47, 0, 8'h77);
    row(13'h1800, 1, 1, 13'h1B00, 8'h99, 13'h1B00, 0, 8'h47, 1, 8'h77);
    row(13'h1800, 1, 0, 13'h1FFF, 8'h00, 13'h1FFF, 0, 8'h47, 0, 8'h77); // out-of-range read
    row(13'h1800, 1, 0, 13'h1FFF, 8'h00, 13'h1FFF, 0, 8'h47, 0, 8'h77);
    row(13'h1800, 1, 0, 13'h1FFF, 8'h00, 13'h1FFF, 0, 8'h47, 1, 8'hFF);
    row(13'h1B00, 0, 0, 13'h0000, 8'h00, 13'h1B00, 0, 8'h47, 0, 8'hFF); // out-of-range video
    row(13'h1B00, 0, 0, 13'h0000, 8'h00, 13'h1B00, 0, 8'hFF, 0, 8'hFF);
    row(13'h1B00, 0, 0, 13'h0000, 8'h00, 13'h1B00, 0, 8'hFF, 0, 8'hFF);
    row(13'h1B00, 1, 1, 13'h0100, 8'hA1, 13'h0100, 1, 8'hFF, 0, 8'hFF); // back-to-back writes
    row(13'h1B00, 1, 1, 13'h0100, 8'hA1, 13'h0100, 0, 8'hFF, 0, 8'hFF);
    row(13'h1B00, 1, 1, 13'h0100, 8'hA1, 13'h0100, 0, 8'hFF, 1, 8'hFF);
    row(13'h1B00, 1, 1, 13'h0101, 8'hA2, 13'h0101, 1, 8'hFF, 0, 8'hFF);
    row(13'h1B00, 1, 1, 13'h0101, 8'hA2, 13'h0101, 0, 8'hFF, 0, 8'hFF);
    row(13'h1B00, 1, 1, 13'h0101, 8'hA2, 13'h0101, 0, 8'hFF, 1, 8'hFF);
    row(13'h1B00, 1, 1, 13'h0102, 8'hA3, 13'h0102, 1, 8'hFF, 0, 8'hFF);
    row(13'h1B00, 1, 1, 13'h0102, 8'hA3, 13'h0102, 0, 8'hFF, 0, 8'hFF);
    row(13'h1B00, 1, 1, 13'h0102, 8'hA3, 13'h0102, 0, 8'hFF, 1, 8'hFF);
    row(13'h1B00, 0, 0, 13'h0000, 8'h00, 13'h0102, 0, 8'hFF, 0, 8'hFF);
    row(13'h1B00, 1, 0, 13'h0101, 8'h00, 13'h0101, 0, 8'hFF, 0, 8'hFF); // read back a write
    row(13'h1B00, 1, 0, 13'h0101, 8'h00, 13'h0101, 0, 8'hFF, 0, 8'hFF);
    row(13'h1B00, 1, 0, 13'h0101, 8'h00, 13'h0101, 0, 8'hFF, 1, 8'hA2);
    row(13'h1B00, 0, 0, 13'h0000, 8'h00, 13'h0101, 0, 8'hFF, 0, 8'hA2);

    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk_pix);
      reset = 1'b0;
      vram_address = vec[i].va;
      cpu_req = vec[i].req; cpu_we = vec[i].we; cpu_addr = vec[i].ca; cpu_wdata = vec[i].wd;
      #1;
      chk($sformatf("row%0d_mem_addr", i), 32'(mem_addr), 32'(vec[i].e_ma));
      chk($sformatf("row%0d_mem_we", i), 32'(mem_we), 32'(vec[i].e_we));
      if (vec[i].e_we) chk($sformatf("row%0d_mem_wdata", i), 32'(mem_wdata), 32'(vec[i].wd));
      chk($sformatf("row%0d_vram_data", i), 32'(vram_data), 32'(vec[i].e_vd));
      chk($sformatf("row%0d_cpu_ack", i), 32'(cpu_ack), 32'(vec[i].e_ack));
      chk($sformatf("row%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(vec[i].e_rd));
    end

    // Reset during ISSUED: transaction dropped, fetch on first cycle after release.
    @(negedge clk_pix);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    #1 chk("mid_issue_addr", 32'(mem_addr), 32'h0123);
    @(negedge clk_pix);
    #1 chk("mid_issued_ack", 32'(cpu_ack), 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(cpu_ack), 32'h0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'h0);
    chk("mid_rst_rdata", 32'(cpu_rdata), 32'h0);
    chk("mid_rst_vram_data", 32'(vram_data), 32'h0);
    @(negedge clk_pix);
    cpu_req = 1'b0;
    #1 chk("mid_rst_hold_ack", 32'(cpu_ack), 32'h0);
    @(negedge clk_pix);
    reset = 1'b0;
    #1;
    chk("post_rst_fetch_addr", 32'(mem_addr), 32'h1B00);
    chk("post_rst_fetch_we", 32'(mem_we), 32'h0);
    chk("post_rst_ack0", 32'(cpu_ack), 32'h0);
    @(negedge clk_pix);
    #1;
    chk("post_rst_vram_data", 32'(vram_data), 32'hFF);
    chk("post_rst_ack1", 32'(cpu_ack), 32'h0);
    @(negedge clk_pix);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040;
    #1 chk("post_rst_idle_issue", 32'(mem_addr), 32'h0040);
    @(negedge clk_pix);
    #1 chk("post_rst_ack2", 32'(cpu_ack), 32'h0);
    @(negedge clk_pix);
    #1;
    chk("post_rst_ack3", 32'(cpu_ack), 32'h1);
    chk("post_rst_rdata", 32'(cpu_rdata), 32'h77);
    @(negedge clk_pix);
    cpu_req = 1'b0;

    // Video busy every cycle: CPU waits without ack, then issues once video settles.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
    for (int i = 0; i < 16; i++) begin
      vram_address = 13'h0200 + 13'(i);
      #1;
      chk($sformatf("starve%0d_addr", i), 32'(mem_addr), 32'(vram_address));
      chk($sformatf("starve%0d_ack", i), 32'(cpu_ack), 32'h0);
      @(negedge clk_pix);
    end
    #1 chk("starve_issue", 32'(mem_addr), 32'h0123);
    @(negedge clk_pix);
    @(negedge clk_pix);
    #1;
    chk("starve_ack", 32'(cpu_ack), 32'h1);
    chk("starve_rdata", 32'(cpu_rdata), 32'h5A);

    // Randomised traffic against the reference model, from a fresh reset.
    @(negedge clk_pix);
    reset = 1'b1; cpu_req = 1'b0; vram_address = 13'd0;
    @(negedge clk_pix);
    for (int i = 0; i < 8192; i++) shadow[i] = ram[i];
    m_va = 13'd0; m_force = 1'b1; m_valid = 1'b0; m_phase = 0;
    m_we_q = 1'b0; m_pend = 8'd0; m_rdata = 8'd0; m_last_addr = 13'd0; prev_ack = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_pix);
      reset = 1'b0;
      if ($urandom_range(3, 0) == 0) vram_address = pick_addr(vram_address);
      if (cpu_req && prev_ack) begin
        if ($urandom_range(1, 0) == 0) cpu_req = 1'b0;
        else new_op();
      end else if (!cpu_req && $urandom_range(9, 0) < 4) begin
        cpu_req = 1'b1;
        new_op();
      end
      #1;

      vid_due   = m_force || (vram_address != m_va);
      cpu_issue = !vid_due && (m_phase == 0) && cpu_req;
      e_we      = cpu_issue && cpu_we && (int'(cpu_addr) < SB);
      e_addr    = vid_due ? vram_address : (cpu_issue ? cpu_addr : m_last_addr);
      e_vd      = m_valid ? view(m_va) : 8'h00;
      e_ack     = (m_phase == 2);

      chk("rnd_mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("rnd_mem_we", 32'(mem_we), 32'(e_we));
      if (e_we) chk("rnd_mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
      chk("rnd_vram_data", 32'(vram_data), 32'(e_vd));
      chk("rnd_cpu_ack", 32'(cpu_ack), 32'(e_ack));
      chk("rnd_cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));

      if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        m_phase = 2;
        if (!m_we_q) m_rdata = m_pend;
      end else if (cpu_issue) begin
        m_phase = 1;
        m_we_q  = cpu_we;
        m_pend  = view(cpu_addr);
        if (e_we) shadow[cpu_addr] = cpu_wdata;
      end
      if (vid_due) begin
        m_va = vram_address; m_force = 1'b0; m_valid = 1'b1;
      end
      m_last_addr = e_addr;
      prev_ack = e_ack;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
